// File: rtl/mgt_01_mul_arbiter.sv
// Round-robin arbiter that shares one iterative Booth multiplier between
// the integer M-unit (port 0, half product) and the FPU mantissa path
// (port 1, full product). A watchdog resets the multiplier if it never
// reports completion, and the pending request is answered with an error.

module mgt_01_mul_arbiter #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                req0_valid_i,
   output logic                req0_ready_o,
   input  logic [XLEN-1:0]     req0_a_i,
   input  logic [XLEN-1:0]     req0_b_i,
   input  logic                req0_hi_i,
   output logic                rsp0_valid_o,
   input  logic                rsp0_ready_i,
   output logic [XLEN-1:0]     rsp0_data_o,
   output logic                rsp0_err_o,
   input  logic                req1_valid_i,
   output logic                req1_ready_o,
   input  logic [XLEN-1:0]     req1_a_i,
   input  logic [XLEN-1:0]     req1_b_i,
   output logic                rsp1_valid_o,
   input  logic                rsp1_ready_i,
   output logic [2*XLEN-1:0]   rsp1_data_o,
   output logic                rsp1_err_o,
   output logic [XLEN-1:0]     mul_multiplier_o,
   output logic [XLEN-1:0]     mul_multiplicand_o,
   output logic                mul_clk_en_o,
   output logic                mul_rst_n_o,
   input  logic [2*XLEN-1:0]   mul_result_i,
   input  logic                mul_valid_i,
   output logic                busy_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      RECOVER
   } state_t;

   state_t              state;
   logic                ptr;
   logic                grant_id;
   logic                hi_q;
   logic                err_q;
   logic [XLEN-1:0]     a_q;
   logic [XLEN-1:0]     b_q;
   logic [2*XLEN-1:0]   result_q;
   logic [CW-1:0]       wd_cnt;
   logic                grant_valid;
   logic                grant_sel;
   logic                rsp_taken;

   // Pick a winner while idle: the pointer breaks ties, a lone requester always wins.
   always_comb begin
      grant_valid  = 1'b0;
      grant_sel    = 1'b0;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      if (state == IDLE && (req0_valid_i || req1_valid_i)) begin
         grant_valid  = 1'b1;
         grant_sel    = (req0_valid_i && req1_valid_i) ? ptr : req1_valid_i;
         req0_ready_o = ~grant_sel;
         req1_ready_o = grant_sel;
      end
   end

   // Shape the captured product for each port and qualify the error flags.
   always_comb begin
      rsp0_data_o = hi_q ? result_q[2*XLEN-1:XLEN] : result_q[XLEN-1:0];
      rsp1_data_o = result_q;
      rsp0_err_o  = err_q & rsp0_valid_o;
      rsp1_err_o  = err_q & rsp1_valid_o;
      rsp_taken   = grant_id ? rsp1_ready_i : rsp0_ready_i;
      busy_o      = (state != IDLE);
      mul_multiplier_o   = a_q;
      mul_multiplicand_o = b_q;
   end

   // Main sequencer: issue, wait for the multiplier or the watchdog, then respond.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= IDLE;
         ptr          <= 1'b0;
         grant_id     <= 1'b0;
         hi_q         <= 1'b0;
         err_q        <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         wd_cnt       <= '0;
         rsp0_valid_o <= 1'b0;
         rsp1_valid_o <= 1'b0;
         mul_clk_en_o <= 1'b0;
         mul_rst_n_o  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  grant_id     <= grant_sel;
                  a_q          <= grant_sel ? req1_a_i : req0_a_i;
                  b_q          <= grant_sel ? req1_b_i : req0_b_i;
                  hi_q         <= grant_sel ? 1'b0 : req0_hi_i;
                  mul_clk_en_o <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               wd_cnt <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (mul_valid_i) begin
                  result_q     <= mul_result_i;
                  err_q        <= 1'b0;
                  mul_clk_en_o <= 1'b0;
                  rsp0_valid_o <= ~grant_id;
                  rsp1_valid_o <= grant_id;
                  state        <= RESP;
               end else if (wd_cnt == WD_LAST) begin
                  mul_clk_en_o <= 1'b0;
                  mul_rst_n_o  <= 1'b0;
                  state        <= RECOVER;
               end else begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
            RECOVER: begin
               mul_rst_n_o  <= 1'b1;
               result_q     <= '0;
               err_q        <= 1'b1;
               rsp0_valid_o <= ~grant_id;
               rsp1_valid_o <= grant_id;
               state        <= RESP;
            end
            RESP: begin
               if (rsp_taken) begin
                  rsp0_valid_o <= 1'b0;
                  rsp1_valid_o <= 1'b0;
                  ptr          <= ~grant_id;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mgt_01_mul_arbiter.sv
// Self-checking bench for mgt_01_mul_arbiter: a behavioural multiplier
// stand-in plus a transaction-level model of grants, latency and results.

module tb_mgt_01_mul_arbiter;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 16;

   logic                clk_i = 1'b0;
   logic                rst_n_i;
   logic                req0_valid_i, req0_ready_o, req0_hi_i;
   logic [XLEN-1:0]     req0_a_i, req0_b_i;
   logic                rsp0_valid_o, rsp0_ready_i, rsp0_err_o;
   logic [XLEN-1:0]     rsp0_data_o;
   logic                req1_valid_i, req1_ready_o;
   logic [XLEN-1:0]     req1_a_i, req1_b_i;
   logic                rsp1_valid_o, rsp1_ready_i, rsp1_err_o;
   logic [2*XLEN-1:0]   rsp1_data_o;
   logic [XLEN-1:0]     mul_multiplier_o, mul_multiplicand_o;
   logic                mul_clk_en_o, mul_rst_n_o;
   logic [2*XLEN-1:0]   mul_result_i;
   logic                mul_valid_i;
   logic                busy_o;

   int                  checks = 0;
   int                  errors = 0;
   logic                modelPtr;
   logic                hang;
   logic [63:0]         lastObs;

   logic                mact;
   int                  mcnt;
   logic [63:0]         mres;

   mgt_01_mul_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk_i              (clk_i),
      .rst_n_i            (rst_n_i),
      .req0_valid_i       (req0_valid_i),
      .req0_ready_o       (req0_ready_o),
      .req0_a_i           (req0_a_i),
      .req0_b_i           (req0_b_i),
      .req0_hi_i          (req0_hi_i),
      .rsp0_valid_o       (rsp0_valid_o),
      .rsp0_ready_i       (rsp0_ready_i),
      .rsp0_data_o        (rsp0_data_o),
      .rsp0_err_o         (rsp0_err_o),
      .req1_valid_i       (req1_valid_i),
      .req1_ready_o       (req1_ready_o),
      .req1_a_i           (req1_a_i),
      .req1_b_i           (req1_b_i),
      .rsp1_valid_o       (rsp1_valid_o),
      .rsp1_ready_i       (rsp1_ready_i),
      .rsp1_data_o        (rsp1_data_o),
      .rsp1_err_o         (rsp1_err_o),
      .mul_multiplier_o   (mul_multiplier_o),
      .mul_multiplicand_o (mul_multiplicand_o),
      .mul_clk_en_o       (mul_clk_en_o),
      .mul_rst_n_o        (mul_rst_n_o),
      .mul_result_i       (mul_result_i),
      .mul_valid_i        (mul_valid_i),
      .busy_o             (busy_o)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   // Signed 32x32 -> 64 product computed with plain arithmetic.
   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
   endfunction

   // Response value a port should see for a given full product.
   function automatic logic [63:0] fmt(input logic port, input logic hi, input logic [63:0] full);
      if (port)
         return full;
      return hi ? {32'd0, full[63:32]} : {32'd0, full[31:0]};
   endfunction

   // Multiplier stand-in: loads on the first enabled cycle, pulses valid after
   // eight more enabled cycles, and can be told to hang forever.
   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mact         <= 1'b0;
         mcnt         <= 0;
         mres         <= '0;
         mul_valid_i  <= 1'b0;
         mul_result_i <= '0;
      end else if (!mul_rst_n_o) begin
         mact        <= 1'b0;
         mcnt        <= 0;
         mul_valid_i <= 1'b0;
      end else if (mul_clk_en_o) begin
         if (!mact) begin
            mact <= 1'b1;
            mcnt <= 1;
            mres <= smul(mul_multiplier_o, mul_multiplicand_o);
         end else if (mul_valid_i) begin
            mact        <= 1'b0;
            mul_valid_i <= 1'b0;
         end else begin
            mcnt <= mcnt + 1;
            if (mcnt == 8 && !hang) begin
               mul_valid_i  <= 1'b1;
               mul_result_i <= mres;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_ready"}, 64'({req1_ready_o, req0_ready_o}), 64'd0);
      checkOutput({tag, "_rsp_valid"}, 64'({rsp1_valid_o, rsp0_valid_o}), 64'd0);
      checkOutput({tag, "_err"}, 64'({rsp1_err_o, rsp0_err_o}), 64'd0);
      checkOutput({tag, "_mul_ctrl"}, 64'({mul_clk_en_o, mul_rst_n_o}), 64'b01);
      checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
      checkOutput({tag, "_operands"}, {mul_multiplier_o, mul_multiplicand_o}, 64'd0);
      checkOutput({tag, "_data"}, rsp1_data_o | {32'd0, rsp0_data_o}, 64'd0);
   endtask

   task automatic doReset();
      @(negedge clk_i);
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      rsp0_ready_i = 1'b0;
      rsp1_ready_i = 1'b0;
      rst_n_i = 1'b1;
      #1 rst_n_i = 1'b0;
      #1 checkReset("reset");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      modelPtr = 1'b0;
   endtask

   // One complete transaction on a single port, with the response held off
   // for 'hold' cycles while the other port tries to get in.
   task automatic applyStimulus(input logic port, input logic [31:0] a, input logic [31:0] b,
                                input logic hi, input int hold, input int expLat, input logic expErr);
      logic [63:0] expData;
      logic [63:0] obs;
      int          cyc;
      int          rstLow;
      int          rstAt;
      expData = fmt(port, hi, expErr ? 64'd0 : smul(a, b));
      @(negedge clk_i);
      if (port == 1'b0) begin
         req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; req0_hi_i = hi;
      end else begin
         req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b;
      end
      #1 checkOutput("req_ready", 64'({req1_ready_o, req0_ready_o}), port ? 64'd2 : 64'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      req0_a_i = $urandom; req0_b_i = $urandom; req0_hi_i = ~hi;
      req1_a_i = $urandom; req1_b_i = $urandom;
      cyc = 1; rstLow = 0; rstAt = -1;
      while (!(rsp0_valid_o || rsp1_valid_o) && cyc < 100) begin
         if (!mul_rst_n_o) begin
            rstLow++;
            rstAt = cyc;
         end
         @(negedge clk_i);
         cyc++;
      end
      checkOutput("latency", 64'(cyc), 64'(expLat));
      checkOutput("mul_rst_pulses", 64'(rstLow), expErr ? 64'd1 : 64'd0);
      if (expErr)
         checkOutput("mul_rst_cycle", 64'(rstAt), 64'(TIMEOUT + 2));
      checkOutput("rsp_port", 64'({rsp1_valid_o, rsp0_valid_o}), port ? 64'd2 : 64'd1);
      checkOutput("operands_held", {mul_multiplier_o, mul_multiplicand_o}, {a, b});
      checkOutput("mul_clk_en_resp", 64'(mul_clk_en_o), 64'd0);
      for (int h = 0; h <= hold; h++) begin
         obs = port ? rsp1_data_o : {32'd0, rsp0_data_o};
         lastObs = obs;
         checkOutput("rsp_data", obs, expData);
         checkOutput("rsp_err", 64'(port ? rsp1_err_o : rsp0_err_o), 64'(expErr));
         if (h > 0)
            checkOutput("no_grant_in_resp", 64'({req1_ready_o, req0_ready_o}), 64'd0);
         if (h == 0 && hold > 0) begin
            if (port) begin
               req0_valid_i = 1'b1; req0_a_i = $urandom; req0_b_i = $urandom;
            end else begin
               req1_valid_i = 1'b1; req1_a_i = $urandom; req1_b_i = $urandom;
            end
            #1;
         end
         if (h == hold) begin
            if (port) rsp1_ready_i = 1'b1;
            else      rsp0_ready_i = 1'b1;
         end
         @(negedge clk_i);
      end
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
      checkOutput("rsp_released", 64'({rsp1_valid_o, rsp0_valid_o}), 64'd0);
      modelPtr = ~port;
   endtask

   initial begin
      logic        pendPort;
      logic [63:0] pendExp;
      int          served;
      int          grants;
      int          seen;

      rst_n_i = 1'b1; hang = 1'b0; modelPtr = 1'b0; lastObs = '0;
      req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0; req0_hi_i = 1'b0;
      req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0;
      rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
      pendPort = 1'b0; pendExp = '0;

      $display("[TB] reset");
      doReset();

      $display("[TB] directed products");
      applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0, 11, 1'b0);
      checkOutput("p0_7x-3_lo", lastObs, 64'h0000_0000_FFFF_FFEB);
      applyStimulus(1'b0, 32'h8000_0000, 32'd2, 1'b1, 0, 11, 1'b0);
      checkOutput("p0_min_x2_hi", lastObs, 64'h0000_0000_FFFF_FFFF);
      applyStimulus(1'b1, 32'h00FF_FFFF, 32'h00FF_FFFF, 1'b0, 0, 11, 1'b0);
      checkOutput("p1_full", lastObs, 64'h0000_FFFF_FE00_0001);

      $display("[TB] held response");
      applyStimulus(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5, 11, 1'b0);

      $display("[TB] watchdog");
      hang = 1'b1;
      applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_0003, 1'b0, 1, TIMEOUT + 3, 1'b1);
      hang = 1'b0;
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 11, 1'b0);
      checkOutput("after_recover", lastObs, 64'h0000_0000_0000_0001);

      $display("[TB] random single-port traffic");
      for (int i = 0; i < 8; i++)
         applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), 11, 1'b0);

      $display("[TB] round robin with both ports saturated");
      doReset();
      rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
      served = 0; grants = 0;
      for (int c = 0; c < 400 && served < 6; c++) begin
         @(negedge clk_i);
         req0_valid_i = 1'b1; req1_valid_i = 1'b1;
         req0_a_i = $urandom; req0_b_i = $urandom; req0_hi_i = 1'($urandom_range(0, 1));
         req1_a_i = $urandom; req1_b_i = $urandom;
         #1;
         if (rsp0_valid_o || rsp1_valid_o) begin
            checkOutput("rr_rsp_port", 64'({rsp1_valid_o, rsp0_valid_o}), pendPort ? 64'd2 : 64'd1);
            checkOutput("rr_rsp_data", pendPort ? rsp1_data_o : {32'd0, rsp0_data_o}, pendExp);
            served++;
            modelPtr = ~pendPort;
         end
         if (busy_o)
            checkOutput("rr_no_grant_busy", 64'({req1_ready_o, req0_ready_o}), 64'd0);
         else begin
            checkOutput("rr_grant", 64'({req1_ready_o, req0_ready_o}), modelPtr ? 64'd2 : 64'd1);
            pendPort = modelPtr;
            pendExp = modelPtr ? fmt(1'b1, 1'b0, smul(req1_a_i, req1_b_i))
                               : fmt(1'b0, req0_hi_i, smul(req0_a_i, req0_b_i));
            grants++;
         end
      end
      checkOutput("rr_served", 64'(served), 64'd6);
      checkOutput("rr_grants", 64'(grants), 64'd6);
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;

      $display("[TB] reset during an operation");
      doReset();
      applyStimulus(1'b1, 32'd5, 32'd6, 1'b0, 0, 11, 1'b0);
      @(negedge clk_i);
      req0_valid_i = 1'b1; req0_a_i = 32'd9; req0_b_i = 32'd9; req0_hi_i = 1'b0;
      @(negedge clk_i);
      req0_valid_i = 1'b0;
      repeat (4) @(negedge clk_i);
      checkOutput("mid_busy", 64'(busy_o), 64'd1);
      rst_n_i = 1'b0;
      #1 checkReset("mid_reset");
      @(negedge clk_i);
      rst_n_i = 1'b1;
      rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk_i);
         if (rsp0_valid_o || rsp1_valid_o || busy_o)
            seen++;
      end
      checkOutput("no_rsp_after_abort", 64'(seen), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
